// File: rtl/flap_input_ctrl.sv
// Flap-button input peripheral: synchroniser, debouncer, free-running timestamp,
// event FIFO and registered read port for the core's load path.
// Optional feature: define FLAP_RELEASE_EVT_EN to also queue release events (kind=1).
module flap_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned TS_WIDTH        = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic        rd_en,
  input  logic        ovf_clr,
  output logic [31:0] rd_data,
  output logic        irq,
  output logic        overflow
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EntW = TS_WIDTH + 1;

  logic                r_sync1;
  logic                r_sync2;
  logic                r_stable;
  logic [DbW-1:0]      r_db_cnt;
  logic [TS_WIDTH-1:0] r_ts;
  logic [EntW-1:0]     r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;
  logic                r_overflow;
  logic [31:0]         r_rd_data;

  logic                w_btn_s;
  logic                w_db_fire;
  logic                w_push;
  logic                w_push_kind;
  logic                w_full;
  logic                w_pop;
  logic                w_wr;
  logic                w_drop;
  logic [EntW-1:0]     w_rd_entry;
  logic [31:0]         w_rd_word;

  assign w_btn_s   = r_sync2;
  assign w_db_fire = (w_btn_s != r_stable) && (r_db_cnt == DbW'(DEBOUNCE_CYCLES - 1));

`ifdef FLAP_RELEASE_EVT_EN
  assign w_push      = w_db_fire;
  assign w_push_kind = ~w_btn_s;  // new level 0 means a release
`else
  assign w_push      = w_db_fire && w_btn_s;
  assign w_push_kind = 1'b0;
`endif

  assign w_full     = (r_count == CntW'(FIFO_DEPTH));
  assign w_pop      = rd_en && (r_count != '0);
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign w_wr       = w_push && (!w_full || w_pop);
  assign w_drop     = w_push && w_full && !w_pop;
  assign w_rd_entry = r_mem[r_rd_ptr];

  assign rd_data  = r_rd_data;
  assign irq      = (r_count != '0);
  assign overflow = r_overflow;

  // Two-flop synchroniser and debounce counter / accepted level.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      if (w_btn_s == r_stable) begin
        r_db_cnt <= '0;
      end else if (w_db_fire) begin
        r_stable <= w_btn_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DbW'(1);
      end
    end
  end

  // Free-running timestamp, wraps naturally at 2^TS_WIDTH.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // Event storage; contents are don't-care while the slot is not counted.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_push_kind, r_ts};
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Assemble the read word from pre-pop state.
  always_comb begin
    w_rd_word        = '0;
    w_rd_word[31]    = w_pop;
    w_rd_word[30]    = r_overflow;
    w_rd_word[29:24] = 6'(r_count);
    if (w_pop) begin
      w_rd_word[23]   = w_rd_entry[TS_WIDTH];
      w_rd_word[22:0] = 23'(w_rd_entry[TS_WIDTH-1:0]);
    end
  end

  // Read register updates only on a strobe and holds otherwise.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_flap_input_ctrl.sv
// Self-checking bench for flap_input_ctrl: queue-based reference model compared every
// cycle, plus directed literal checks. Honours FLAP_RELEASE_EVT_EN if defined.
module tb_flap_input_ctrl;

  localparam int D     = 16;
  localparam int DEPTH = 4;
  localparam int TSW   = 16;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        btn_raw = 1'b0;
  logic        rd_en = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] rd_data;
  logic        irq;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  flap_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH),
    .TS_WIDTH       (TSW)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .btn_raw (btn_raw),
    .rd_en   (rd_en),
    .ovf_clr (ovf_clr),
    .rd_data (rd_data),
    .irq     (irq),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: btn_s is the raw level two edges late; the accepted level flips once
  // the last D post-reset samples all differ from it; events go to a bounded queue.
  logic        m_r1, m_r2, m_stable, m_ovf;
  logic [31:0] m_rd;
  bit          m_hist[$];
  int          m_q[$];
  int          m_ts;
  bit          m_live = 0;

  always @(posedge clock) begin
    logic bs;
    bit   all_diff, upd, push, drop;
    int   ent, cnt;
    if (rst) begin
      m_r1 = 0; m_r2 = 0; m_stable = 0; m_ovf = 0; m_rd = '0; m_ts = 0;
      m_hist.delete();
      m_q.delete();
      m_live = 1;
    end else begin
      bs = m_r2;
      m_r2 = m_r1;
      m_r1 = btn_raw;
      m_hist.push_back(bs);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      upd = 0;
      if (m_hist.size() == D) begin
        all_diff = 1;
        foreach (m_hist[i]) if (m_hist[i] == m_stable) all_diff = 0;
        upd = all_diff;
      end
`ifdef FLAP_RELEASE_EVT_EN
      push = upd;
      ent  = ((bs ? 0 : 1) << 23) | m_ts;
`else
      push = upd && bs;
      ent  = m_ts;
`endif
      if (rd_en) begin
        cnt = m_q.size();
        if (cnt > 0) m_rd = {1'b1, m_ovf, 6'(cnt), 24'(m_q.pop_front())};
        else         m_rd = {1'b0, m_ovf, 6'(cnt), 24'd0};
      end
      drop = 0;
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(ent);
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (upd) m_stable = bs;
      m_ts = (m_ts + 1) % (1 << TSW);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_live) begin
      chk("rd_data", rd_data, m_rd);
      chk("irq", {31'd0, irq}, {31'd0, (m_q.size() != 0)});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press();
    btn_raw = 1'b1;
    tick(40);
    btn_raw = 1'b0;
    tick(40);
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin : main
    logic [15:0] tsv [4];
    logic [15:0] dts;

    // Reset and idle.
    tick(1);
    rst = 1'b0;
    tick(50);
    chk("idle_rd_data", rd_data, 32'h0);
    chk("idle_irq", {31'd0, irq}, 32'd0);
    chk("idle_ovf", {31'd0, overflow}, 32'd0);

    // Single clean press: accepted on the 18th edge after the raw edge.
    btn_raw = 1'b1;
    repeat (17) @(posedge clock);
    #1 chk("irq_before_accept", {31'd0, irq}, 32'd0);
    @(posedge clock);
    #1 chk("irq_at_accept", {31'd0, irq}, 32'd1);
    @(negedge clock);
    tick(22);
    btn_raw = 1'b0;
    tick(40);
    rd();
    chk("press_valid", {31'd0, rd_data[31]}, 32'd1);
    chk("press_count", {26'd0, rd_data[29:24]}, 32'd1);
    chk("press_kind", {31'd0, rd_data[23]}, 32'd0);
    rd();
    chk("empty_valid", {31'd0, rd_data[31]}, 32'd0);

    // Glitches shorter than the debounce window.
    repeat (10) begin
      btn_raw = 1'b1;
      tick(5);
      btn_raw = 1'b0;
      tick(5);
    end
    tick(30);
    chk("glitch_irq", {31'd0, irq}, 32'd0);

    // Overflow: six presses into a four-deep queue.
    do_reset();
    repeat (6) press();
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd();
      chk("ovf_rd_valid", {31'd0, rd_data[31]}, 32'd1);
      chk("ovf_rd_count", {26'd0, rd_data[29:24]}, 32'(4 - i));
      tsv[i] = rd_data[15:0];
`ifdef FLAP_RELEASE_EVT_EN
      chk("ovf_rd_kind", {31'd0, rd_data[23]}, 32'(i % 2));
`else
      chk("ovf_rd_kind", {31'd0, rd_data[23]}, 32'd0);
`endif
    end
`ifndef FLAP_RELEASE_EVT_EN
    for (int i = 1; i < 4; i++) begin
      dts = tsv[i] - tsv[i-1];
      chk("ts_spacing", {16'd0, dts}, 32'd80);
    end
`endif
    rd();
    chk("ovf_5th_valid", {31'd0, rd_data[31]}, 32'd0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO with a press accepted on the same edge as a read.
`ifdef FLAP_RELEASE_EVT_EN
    repeat (2) press();
`else
    repeat (4) press();
`endif
    chk("full_ovf_pre", {31'd0, overflow}, 32'd0);
    btn_raw = 1'b1;
    tick(17);
    rd();
    chk("full_pop_valid", {31'd0, rd_data[31]}, 32'd1);
    chk("full_pop_count", {26'd0, rd_data[29:24]}, 32'd4);
    chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
    rd();
    chk("full_still4", {26'd0, rd_data[29:24]}, 32'd4);
    tick(20);
    btn_raw = 1'b0;
    tick(40);
    repeat (4) rd();

    // Press then release; then reset with events queued.
    do_reset();
    press();
    rd();
    chk("pr_first_valid", {31'd0, rd_data[31]}, 32'd1);
    chk("pr_first_kind", {31'd0, rd_data[23]}, 32'd0);
    rd();
`ifdef FLAP_RELEASE_EVT_EN
    chk("pr_second_valid", {31'd0, rd_data[31]}, 32'd1);
    chk("pr_second_kind", {31'd0, rd_data[23]}, 32'd1);
`else
    chk("pr_second_valid", {31'd0, rd_data[31]}, 32'd0);
`endif
    repeat (3) press();
    chk("queued_irq", {31'd0, irq}, 32'd1);
    do_reset();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rd_data", rd_data, 32'h0);
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
